// File: rtl/fc_hwpe_copy_engine.sv
// APB-programmed TCDM word copy engine: batches of up to N_MASTER_PORT words, read phase then write phase.
// APB is zero-wait; lanes hold req until gnt, FSM stalls per phase. FC_HWPE_CYCLE_CNT_EN adds CYCLES at 0x14.
module fc_hwpe_copy_engine #(
    parameter int N_MASTER_PORT  = 4,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int LEN_WIDTH      = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        test_mode_i,
    input  logic [APB_ADDR_WIDTH-1:0]   apb_paddr_i,
    input  logic [31:0]                 apb_pwdata_i,
    input  logic                        apb_pwrite_i,
    input  logic                        apb_psel_i,
    input  logic                        apb_penable_i,
    output logic [31:0]                 apb_prdata_o,
    output logic                        apb_pready_o,
    output logic                        apb_pslverr_o,
    output logic [N_MASTER_PORT-1:0]    tcdm_req_o,
    input  logic [N_MASTER_PORT-1:0]    tcdm_gnt_i,
    output logic [N_MASTER_PORT*32-1:0] tcdm_add_o,
    output logic [N_MASTER_PORT-1:0]    tcdm_wen_o,
    output logic [N_MASTER_PORT*4-1:0]  tcdm_be_o,
    output logic [N_MASTER_PORT*32-1:0] tcdm_wdata_o,
    input  logic [N_MASTER_PORT*32-1:0] tcdm_r_rdata_i,
    input  logic [N_MASTER_PORT-1:0]    tcdm_r_valid_i,
    output logic [1:0]                  evt_o,
    output logic                        busy_o
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_RDW, S_WR, S_DONE} state_t;

    state_t                         state_q, state_d;
    logic [31:0]                    src_q, src_d, dst_q, dst_d;
    logic [LEN_WIDTH-1:0]           len_q, len_d, rem_q, rem_d, off_q, off_d, nb;
    logic [N_MASTER_PORT-1:0]       gnt_done_q, gnt_done_d, rvld_q, rvld_d, active, req_vec, wen_vec;
    logic [N_MASTER_PORT-1:0][31:0] data_q, data_d, add_vec, wdata_vec, rdata_vec;
    logic [N_MASTER_PORT-1:0][3:0]  be_vec;
    logic                           done_q, done_d, err_q, err_d, err_evt_q, err_evt_d;
    logic                           busy, access, wr_acc, mapped, start_ok, all_gnt, all_rvld;
    logic [2:0]                     reg_idx;
    logic                           unused_in;

    assign unused_in    = ^{test_mode_i, apb_paddr_i};
    assign access       = apb_psel_i & apb_penable_i;
    assign reg_idx      = apb_paddr_i[4:2];
    assign busy         = (state_q != S_IDLE);
    assign wr_acc       = access & apb_pwrite_i & mapped;
    assign rdata_vec    = tcdm_r_rdata_i;
    assign apb_pready_o = 1'b1;
    assign apb_pslverr_o = access & ~mapped;
    assign busy_o       = busy;
    assign evt_o        = {err_evt_q, state_q == S_DONE};
    assign tcdm_req_o   = req_vec;
    assign tcdm_wen_o   = wen_vec;
    assign tcdm_add_o   = add_vec;
    assign tcdm_be_o    = be_vec;
    assign tcdm_wdata_o = wdata_vec;

`ifdef FC_HWPE_CYCLE_CNT_EN
    logic [31:0] cyc_q, cyc_d;
    assign mapped = (reg_idx <= 3'd5);

    always_comb begin
        cyc_d = cyc_q;
        if (start_ok) begin
            cyc_d = '0;
        end else if (busy && cyc_q != 32'hFFFF_FFFF) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cyc_q <= '0;
        else       cyc_q <= cyc_d;
    end
`else
    assign mapped = (reg_idx <= 3'd4);
`endif

    // Register writes; CTRL clear is applied before the start is evaluated.
    always_comb begin
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        done_d    = done_q;
        err_d     = err_q;
        err_evt_d = 1'b0;
        start_ok  = 1'b0;
        if (wr_acc) begin
            case (reg_idx)
                3'd0: begin
                    if (apb_pwdata_i[1]) begin
                        done_d = 1'b0;
                        err_d  = 1'b0;
                    end
                    if (apb_pwdata_i[0]) begin
                        if (busy) begin
                            err_d     = 1'b1;
                            err_evt_d = 1'b1;
                        end else begin
                            start_ok = 1'b1;
                        end
                    end
                end
                3'd2, 3'd3, 3'd4: begin
                    if (busy) begin
                        err_d     = 1'b1;
                        err_evt_d = 1'b1;
                    end else if (reg_idx == 3'd2) begin
                        src_d = {apb_pwdata_i[31:2], 2'b00};
                    end else if (reg_idx == 3'd3) begin
                        dst_d = {apb_pwdata_i[31:2], 2'b00};
                    end else begin
                        len_d = apb_pwdata_i[LEN_WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
        if (state_q == S_DONE) done_d = 1'b1;
    end

    always_comb begin
        apb_prdata_o = '0;
        if (access && !apb_pwrite_i) begin
            case (reg_idx)
                3'd1: apb_prdata_o = {29'd0, err_q, done_q, busy};
                3'd2: apb_prdata_o = src_q;
                3'd3: apb_prdata_o = dst_q;
                3'd4: apb_prdata_o = 32'(len_q);
`ifdef FC_HWPE_CYCLE_CNT_EN
                3'd5: apb_prdata_o = cyc_q;
`endif
                default: apb_prdata_o = '0;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        off_d      = off_q;
        gnt_done_d = gnt_done_q;
        rvld_d     = rvld_q;
        data_d     = data_q;
        active     = '0;
        req_vec    = '0;
        for (int k = 0; k < N_MASTER_PORT; k++) begin
            active[k] = (LEN_WIDTH'(k) < rem_q);
        end
        nb = (rem_q < LEN_WIDTH'(N_MASTER_PORT)) ? rem_q : LEN_WIDTH'(N_MASTER_PORT);
        if (state_q == S_RD || state_q == S_WR) begin
            req_vec = active & ~gnt_done_q;
        end
        all_gnt = &(gnt_done_q | (req_vec & tcdm_gnt_i) | ~active);
        // Responses may land while other lanes are still waiting for grant.
        if (state_q == S_RD || state_q == S_RDW) begin
            for (int k = 0; k < N_MASTER_PORT; k++) begin
                if (tcdm_r_valid_i[k] && active[k]) begin
                    data_d[k] = rdata_vec[k];
                    rvld_d[k] = 1'b1;
                end
            end
        end
        all_rvld = &(rvld_d | ~active);
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    rem_d      = len_q;
                    off_d      = '0;
                    gnt_done_d = '0;
                    rvld_d     = '0;
                    state_d    = (len_q == '0) ? S_DONE : S_RD;
                end
            end
            S_RD: begin
                gnt_done_d = gnt_done_q | (req_vec & tcdm_gnt_i);
                if (all_gnt) begin
                    gnt_done_d = '0;
                    state_d    = S_RDW;
                end
            end
            S_RDW: begin
                if (all_rvld) begin
                    rvld_d  = '0;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                gnt_done_d = gnt_done_q | (req_vec & tcdm_gnt_i);
                if (all_gnt) begin
                    gnt_done_d = '0;
                    off_d      = off_q + nb;
                    rem_d      = rem_q - nb;
                    state_d    = (rem_q == nb) ? S_DONE : S_RD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wen_vec   = '0;
        add_vec   = '0;
        be_vec    = '0;
        wdata_vec = '0;
        for (int k = 0; k < N_MASTER_PORT; k++) begin
            if (req_vec[k]) begin
                be_vec[k] = 4'hF;
                if (state_q == S_RD) begin
                    wen_vec[k] = 1'b1;
                    add_vec[k] = src_q + ((32'(off_q) + 32'(k)) << 2);
                end else begin
                    add_vec[k]   = dst_q + ((32'(off_q) + 32'(k)) << 2);
                    wdata_vec[k] = data_q[k];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            rem_q      <= '0;
            off_q      <= '0;
            gnt_done_q <= '0;
            rvld_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_evt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            off_q      <= off_d;
            gnt_done_q <= gnt_done_d;
            rvld_q     <= rvld_d;
            data_q     <= data_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_evt_q  <= err_evt_d;
        end
    end
endmodule

// File: tb/tb_fc_hwpe_copy_engine.sv
// Directed bench for fc_hwpe_copy_engine: APB programming, cycle-exact batch timing, stalls, errors, reset.
module tb_fc_hwpe_copy_engine;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0]         paddr, pwdata, prdata;
    logic                pwrite, psel, penable, pready, pslverr;
    logic [N-1:0]        req, gnt, wen, rvld;
    logic [N-1:0][31:0]  add_v, wdata_v, rdata_v;
    logic [N-1:0][3:0]   be_v;
    logic [1:0]          evt;
    logic                busy;
    logic [31:0]         wmem [0:4095];
    int                  lane2_delay;
    int                  age2;
    int                  checks;
    int                  errors;

    fc_hwpe_copy_engine #(.N_MASTER_PORT(N), .APB_ADDR_WIDTH(32), .LEN_WIDTH(16)) dut (
        .clk_i(clk), .rst_i(rst), .test_mode_i(1'b0),
        .apb_paddr_i(paddr), .apb_pwdata_i(pwdata), .apb_pwrite_i(pwrite),
        .apb_psel_i(psel), .apb_penable_i(penable), .apb_prdata_o(prdata),
        .apb_pready_o(pready), .apb_pslverr_o(pslverr),
        .tcdm_req_o(req), .tcdm_gnt_i(gnt), .tcdm_add_o(add_v), .tcdm_wen_o(wen),
        .tcdm_be_o(be_v), .tcdm_wdata_o(wdata_v), .tcdm_r_rdata_i(rdata_v),
        .tcdm_r_valid_i(rvld), .evt_o(evt), .busy_o(busy)
    );

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] dst_word(input logic [31:0] a);
        return wmem[a[13:2]];
    endfunction

    // Memory: instant grant (lane 2 reads optionally delayed), read data one cycle after grant.
    always_comb begin
        gnt = req;
        if (req[2] && wen[2] && age2 < lane2_delay) gnt[2] = 1'b0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rvld <= '0;
            rdata_v <= '0;
            age2 <= 0;
            for (int i = 0; i < 4096; i++) wmem[i] <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                rvld[k] <= req[k] & gnt[k] & wen[k];
                if (req[k] && gnt[k] && wen[k]) rdata_v[k] <= pat(add_v[k]);
                if (req[k] && gnt[k] && !wen[k]) wmem[add_v[k][13:2]] <= wdata_v[k];
            end
            age2 <= (req[2] && !gnt[2]) ? age2 + 1 : 0;
        end
    end

    task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
        paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_rd(input logic [31:0] a, output logic [31:0] d, output logic e);
        paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b1;
        @(negedge clk);
        d = prdata; e = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e;
        checks++; if (req !== 4'h0 || busy !== 1'b0 || evt !== 2'b00) begin
            errors++; $display("FAIL reset_outputs req=%h busy=%b evt=%b exp 0/0/0", req, busy, evt);
        end
        apb_rd(32'h04, d, e);
        checks++; if (d !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL reset_status got %h/%b exp 0/0", d, e); end
        apb_rd(32'h08, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_src got %h exp 0", d); end
    endtask

    task automatic test_regs();
        logic [31:0] d; logic e;
        apb_wr(32'h08, 32'h0000_1003);
        apb_rd(32'h08, d, e);
        checks++; if (d !== 32'h0000_1000) begin errors++; $display("FAIL src_align got %h exp 00001000", d); end
        apb_wr(32'h0C, 32'hFFFF_FFFE);
        apb_rd(32'h0C, d, e);
        checks++; if (d !== 32'hFFFF_FFFC) begin errors++; $display("FAIL dst_align got %h exp fffffffc", d); end
        apb_rd(32'h1C, d, e);
        checks++; if (e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL unmapped_1c got %h/%b exp 0/1", d, e); end
        apb_rd(32'h00, d, e);
        checks++; if (d !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL ctrl_read got %h/%b exp 0/0", d, e); end
    endtask

    task automatic test_copy8();
        logic [3:0] exp_req [8] = '{4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0};
        logic [3:0] exp_wen [8] = '{4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
        logic       exp_bsy [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] exp_evt [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
        logic [31:0] d; logic e;
        apb_wr(32'h08, 32'h1000);
        apb_wr(32'h0C, 32'h2000);
        apb_wr(32'h10, 32'd8);
        apb_wr(32'h00, 32'h1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++; if (req !== exp_req[c] || wen !== exp_wen[c]) begin
                errors++; $display("FAIL copy8_req T+%0d req=%h wen=%h exp %h/%h", c + 1, req, wen, exp_req[c], exp_wen[c]);
            end
            checks++; if (busy !== exp_bsy[c] || evt !== exp_evt[c]) begin
                errors++; $display("FAIL copy8_busy_evt T+%0d busy=%b evt=%b exp %b/%b", c + 1, busy, evt, exp_bsy[c], exp_evt[c]);
            end
            if (c == 0) begin
                checks++; if (add_v[3] !== 32'h100C || be_v[3] !== 4'hF) begin
                    errors++; $display("FAIL copy8_rd_addr got %h/%h exp 0000100c/f", add_v[3], be_v[3]);
                end
            end
            if (c == 5) begin
                checks++; if (add_v[1] !== 32'h2014 || wdata_v[1] !== pat(32'h1014)) begin
                    errors++; $display("FAIL copy8_wr_lane1 got %h/%h exp 00002014/%h", add_v[1], wdata_v[1], pat(32'h1014));
                end
            end
        end
        @(posedge clk); #1;
        apb_rd(32'h04, d, e);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL copy8_status got %h exp 2", d); end
        apb_rd(32'h14, d, e);
`ifdef FC_HWPE_CYCLE_CNT_EN
        checks++; if (d !== 32'd7 || e !== 1'b0) begin errors++; $display("FAIL cycles got %0d/%b exp 7/0", d, e); end
`else
        checks++; if (d !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL cycles_unmapped got %h/%b exp 0/1", d, e); end
`endif
        for (int i = 0; i < 8; i++) begin
            checks++; if (dst_word(32'h2000 + 4 * i) !== pat(32'h1000 + 4 * i)) begin
                errors++; $display("FAIL copy8_data[%0d] got %h exp %h", i, dst_word(32'h2000 + 4 * i), pat(32'h1000 + 4 * i));
            end
        end
        apb_wr(32'h00, 32'h2);
    endtask

    task automatic test_partial();
        apb_wr(32'h08, 32'h1100);
        apb_wr(32'h0C, 32'h2100);
        apb_wr(32'h10, 32'd6);
        apb_wr(32'h00, 32'h1);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 4) begin
                checks++; if (req !== 4'b0011 || wen !== 4'b0011) begin
                    errors++; $display("FAIL partial_rd2 req=%h wen=%h exp 3/3", req, wen);
                end
            end
            if (c == 6) begin
                checks++; if (req !== 4'b0011 || wen !== 4'b0000) begin
                    errors++; $display("FAIL partial_wr2 req=%h wen=%h exp 3/0", req, wen);
                end
            end
            if (c == 7) begin
                checks++; if (evt !== 2'b01) begin errors++; $display("FAIL partial_done evt=%b exp 01", evt); end
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            checks++; if (dst_word(32'h2100 + 4 * i) !== pat(32'h1100 + 4 * i)) begin
                errors++; $display("FAIL partial_data[%0d] got %h exp %h", i, dst_word(32'h2100 + 4 * i), pat(32'h1100 + 4 * i));
            end
        end
        checks++; if (dst_word(32'h2118) !== 32'h0) begin
            errors++; $display("FAIL partial_overrun got %h exp 0", dst_word(32'h2118));
        end
        apb_wr(32'h00, 32'h2);
    endtask

    task automatic test_stall();
        logic [3:0] exp_req [7] = '{4'hF, 4'h4, 4'h4, 4'h4, 4'h0, 4'hF, 4'h0};
        lane2_delay = 3;
        apb_wr(32'h08, 32'h1200);
        apb_wr(32'h0C, 32'h2200);
        apb_wr(32'h10, 32'd4);
        apb_wr(32'h00, 32'h1);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            checks++; if (req !== exp_req[c]) begin
                errors++; $display("FAIL stall_req T+%0d got %h exp %h", c + 1, req, exp_req[c]);
            end
            if (c == 6) begin
                checks++; if (evt !== 2'b01) begin errors++; $display("FAIL stall_done evt=%b exp 01", evt); end
            end
        end
        @(posedge clk); #1;
        lane2_delay = 0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (dst_word(32'h2200 + 4 * i) !== pat(32'h1200 + 4 * i)) begin
                errors++; $display("FAIL stall_data[%0d] got %h exp %h", i, dst_word(32'h2200 + 4 * i), pat(32'h1200 + 4 * i));
            end
        end
        apb_wr(32'h00, 32'h2);
    endtask

    task automatic test_busy_err();
        logic [31:0] d; logic e; logic seen;
        apb_wr(32'h08, 32'h1300);
        apb_wr(32'h0C, 32'h2300);
        apb_wr(32'h10, 32'd8);
        apb_wr(32'h00, 32'h1);
        apb_wr(32'h00, 32'h1);
        @(negedge clk);
        checks++; if (evt !== 2'b10) begin errors++; $display("FAIL busy_start_evt got %b exp 10", evt); end
        @(posedge clk); #1;
        apb_wr(32'h10, 32'd5);
        @(negedge clk);
        checks++; if (evt !== 2'b10) begin errors++; $display("FAIL busy_len_evt got %b exp 10", evt); end
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (evt[0]) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL busy_done_timeout got 0 exp 1"); end
        @(posedge clk); #1;
        apb_rd(32'h04, d, e);
        checks++; if (d !== 32'h6) begin errors++; $display("FAIL busy_status got %h exp 6", d); end
        apb_rd(32'h10, d, e);
        checks++; if (d !== 32'd8) begin errors++; $display("FAIL busy_len_kept got %0d exp 8", d); end
        checks++; if (dst_word(32'h231C) !== pat(32'h131C)) begin
            errors++; $display("FAIL busy_data got %h exp %h", dst_word(32'h231C), pat(32'h131C));
        end
        apb_wr(32'h00, 32'h2);
        apb_rd(32'h04, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL clear_status got %h exp 0", d); end
    endtask

    task automatic test_len0();
        logic [31:0] d; logic e;
        apb_wr(32'h10, 32'd0);
        apb_wr(32'h00, 32'h1);
        @(negedge clk);
        checks++; if (evt !== 2'b01 || busy !== 1'b1 || req !== 4'h0) begin
            errors++; $display("FAIL len0_done evt=%b busy=%b req=%h exp 01/1/0", evt, busy, req);
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || evt !== 2'b00) begin
            errors++; $display("FAIL len0_idle busy=%b evt=%b exp 0/00", busy, evt);
        end
        @(posedge clk); #1;
        apb_rd(32'h04, d, e);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL len0_status got %h exp 2", d); end
        apb_wr(32'h00, 32'h3);
        @(negedge clk);
        checks++; if (evt !== 2'b01) begin errors++; $display("FAIL clear_start evt=%b exp 01", evt); end
        @(posedge clk); #1;
        apb_rd(32'h04, d, e);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL clear_start_status got %h exp 2", d); end
        apb_rd(32'h1C, d, e);
        checks++; if (e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL len0_unmapped got %h/%b exp 0/1", d, e); end
    endtask

    task automatic test_rst_mid();
        logic [31:0] d; logic e; logic bad;
        apb_wr(32'h08, 32'h1000);
        apb_wr(32'h0C, 32'h2400);
        apb_wr(32'h10, 32'd8);
        apb_wr(32'h00, 32'h1);
        repeat (3) @(negedge clk);
        checks++; if (req !== 4'hF || wen !== 4'h0) begin
            errors++; $display("FAIL rst_pre_wr req=%h wen=%h exp f/0", req, wen);
        end
        #1 rst = 1'b1;
        #1;
        checks++; if (req !== 4'h0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_req_drop req=%h busy=%b exp 0/0", req, busy);
        end
        @(posedge clk); #1 rst = 1'b0;
        apb_rd(32'h04, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_status got %h exp 0", d); end
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (evt !== 2'b00 || req !== 4'h0) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL rst_no_event got %b exp 0", bad); end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; errors = 0; lane2_delay = 0;
        paddr = '0; pwdata = '0; pwrite = 1'b0; psel = 1'b0; penable = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_regs();
        test_copy8();
        test_partial();
        test_stall();
        test_busy_err();
        test_len0();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
